mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory stage of the pipelined RISC-V core, directly downstream of the ALU. Takes the EX/MEM operands (ALU result as address or pass-through value, store data, control), runs byte/half/word loads and stores over a request/acknowledge data-memory bus, and aligns and extends load data. Presents one registered write-back beat to the WB stage per instruction. Stalls the pipeline while a bus transaction is outstanding.

## Interface

Reset is asynchronous, active-low (`rst_n`), on a single clock (`clk`).

Parameters:
- `ADDR_W`, default 32: address width; `mem_addr` is `ADDR_W` bits, the low 2 bits always 0.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  EX/MEM holds a valid instruction
- `ex_alu_result`  in  32  ALU result: byte address for loads/stores, write-back value otherwise
- `ex_store_data`  in  32  rs2 value for stores
- `ex_mem_read` / `ex_mem_write`  in  1 each  load / store
- `ex_funct3`  in  3  access size and sign
- `ex_rd`  in  5  destination register
- `ex_reg_write`  in  1  instruction writes rd
- `flush`  in  1  kill the instruction offered this cycle
- `ex_ready`  out  1  instruction accepted this cycle when `ex_valid` is high
- `stall`  out  1  `ex_valid & ~ex_ready`, to the hazard unit
- `mem_req`  out  1  bus request, held until ack
- `mem_we`  out  1  write request
- `mem_addr`  out  ADDR_W  word-aligned address
- `mem_wdata`  out  32  lane-shifted store data
- `mem_wstrb`  out  4  byte enables
- `mem_ack`  in  1  transaction done; `mem_rdata` valid this cycle
- `mem_rdata`  in  32  read word
- `wb_valid`  out  1  one-cycle write-back beat
- `wb_rd`  out  5  destination register
- `wb_reg_write`  out  1  write enable for the register file
- `wb_data`  out  32  write-back value
- `fault`  out  1  one-cycle pulse: misaligned or illegal access, no bus activity

## Operation

- FSM states: IDLE, BUS, RESP.
- IDLE: `ex_ready`=1. On `ex_valid & ~flush`, latch all `ex_*` inputs.
  - Non-memory op, or a fault: go to RESP.
  - Legal memory op: compute address/strobe/data and go to BUS.
- BUS: `mem_req`=1 with stable `mem_we/addr/wdata/wstrb`; `ex_ready`=0. On `mem_ack`, latch `mem_rdata` and go to RESP.
- RESP: `wb_valid`=1 for one cycle, then return to IDLE; `ex_ready`=0.
- Write-back data selection:
  - Pass-through: `wb_data`=latched `ex_alu_result`.
  - Loads: extracted lane, extended per funct3.
  - Stores: `wb_reg_write`=0.
- Loads, by funct3:
  - 000 LB / 100 LBU: byte at addr[1:0], sign- / zero-extended.
  - 001 LH / 101 LHU: half at addr[1], sign- / zero-extended.
  - 010 LW: whole word.
- Stores, by funct3:
  - 000 SB: strobe `4'b0001<<addr[1:0]`, byte replicated ×4.
  - 001 SH: strobe `4'b0011<<{addr[1],1'b0}`, half replicated ×2.
  - 010 SW: strobe `4'b1111`.
- Fault conditions:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Any other funct3 on a memory op.
  - `ex_mem_read & ex_mem_write` both set.
- Fault response: no bus request; RESP beat with `wb_reg_write`=0 and `fault`=1 in that same cycle.
- `flush` in BUS or RESP: the bus transaction still completes, so stores are never torn. The resulting beat is emitted with `wb_reg_write` forced to 0.
- `mem_ack` outside BUS is ignored.

## Timing

- Reset values of outputs: all outputs 0 except `ex_ready`=1; state IDLE. Reset asserted during BUS drops `mem_req` immediately; the pending transaction is abandoned.
- Pass-through / fault latency: accept at edge N, `wb_valid` high in cycle N+1, `ex_ready` high again in N+2.
- Memory op latency:
  - Accept at edge N; `mem_req` high from cycle N+1.
  - Ack in cycle N+k (k≥1) → `wb_valid` in N+k+1.
  - Back-to-back throughput: one memory op per k+2 cycles.
- Same-cycle ack: `mem_ack` may be high in the first cycle of `mem_req`.
- Bus outputs are registered and do not change while `mem_req`=1.
- `wb_*` are registered and held between beats; only `wb_valid` pulses.

## Structure

- Shared package `mem_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State enum.
  - Lane-extract and strobe helper functions.
- One sub-module, `load_align` (combinational): inputs `rdata`, `addr[1:0]`, `funct3`; output extended 32-bit value. It is reused by the future cache.

## Test plan

- ALU pass-through: `ex_alu_result`=32'h0000_00A5, rd=5, no mem op → `wb_valid` in next cycle, `wb_data`=32'hA5, `wb_reg_write`=1, no `mem_req`.
- LB/LBU, addr 32'h103, `mem_rdata`=32'h80xx_xxxx, ack after 3 cycles:
  - LB → `mem_addr`=32'h100, `wb_data`=32'hFFFF_FF80.
  - LBU → `wb_data`=32'h80.
  - `stall` high for 4 cycles.
- SH, addr 32'h202, data 32'h1234_BEEF → `mem_wstrb`=4'b1100, `mem_wdata`=32'hBEEF_BEEF, `mem_we`=1, beat with `wb_reg_write`=0.
- LW at 32'h301 → `fault` pulse, `wb_reg_write`=0, `mem_req` never asserted; funct3=3'b011 load gives the same response.
- `flush` in the second BUS cycle of an SW → bus store still completes with strobe 4'hF; beat has `wb_reg_write`=0.
- `rst_n` low mid-BUS → `mem_req`=0 immediately, `ex_ready`=1; a late `mem_ack` produces no `wb_valid`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: funct3 codes, FSM states and
// lane/strobe helpers used by the access unit and the load aligner.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] a);
    logic [7:0] b;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] lane_half(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << {a[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Extracts the addressed byte/half from a read word and sign/zero-extends it.
// Purely combinational so the cache can share it later.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = lane_byte(rdata, addr);
  assign h = lane_half(rdata, addr[1]);

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'h0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues loads/stores on a req/ack bus and emits one
// registered write-back beat per accepted instruction.
//
// state  | meaning
// IDLE   | ready, accepting the next EX/MEM instruction
// BUS    | mem_req held, waiting for mem_ack
// RESP   | wb_valid beat presented for one cycle
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              flush,
  output logic              ex_ready,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       wb_data,
  output logic              fault
);

  state_t      state;
  logic [31:0] alu_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [4:0]  rd_q;
  logic        load_q, rw_q, flushed_q, wb_rw_q;
  logic        is_mem, bad;
  logic [31:0] ld_data;

  assign is_mem = ex_mem_read | ex_mem_write;
  assign bad    = is_mem & ((ex_mem_read & ex_mem_write)
                          | ~f3_legal(ex_funct3, ex_mem_read)
                          | misaligned(ex_funct3, ex_alu_result[1:0]));

  load_align u_align (
    .rdata (mem_rdata),
    .addr  (lo_q),
    .funct3(f3_q),
    .data  (ld_data)
  );

  assign stall = ex_valid & ~ex_ready;
  // A flush landing on the beat cycle still kills the register write.
  assign wb_reg_write = wb_rw_q & ~(flush & (state == S_RESP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ex_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_rw_q   <= 1'b0;
      wb_data   <= '0;
      fault     <= 1'b0;
      alu_q     <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      rd_q      <= '0;
      load_q    <= 1'b0;
      rw_q      <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid && !flush) begin
            alu_q     <= ex_alu_result;
            f3_q      <= ex_funct3;
            lo_q      <= ex_alu_result[1:0];
            rd_q      <= ex_rd;
            load_q    <= ex_mem_read;
            rw_q      <= ex_reg_write;
            flushed_q <= 1'b0;
            ex_ready  <= 1'b0;
            if (!is_mem || bad) begin
              state    <= S_RESP;
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= ex_alu_result;
              wb_rw_q  <= ex_reg_write & ~bad;
              fault    <= bad;
            end else begin
              state     <= S_BUS;
              mem_req   <= 1'b1;
              mem_we    <= ex_mem_write;
              mem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
              mem_wdata <= ex_mem_write ? store_lanes(ex_funct3, ex_store_data) : 32'h0;
              mem_wstrb <= ex_mem_write ? store_strb(ex_funct3, ex_alu_result[1:0]) : 4'h0;
            end
          end
        end
        S_BUS: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_ack) begin
            state    <= S_RESP;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= load_q ? ld_data : alu_q;
            wb_rw_q  <= load_q & rw_q & ~flushed_q & ~flush;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          ex_ready <= 1'b1;
          if (flush) wb_rw_q <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          ex_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table for single instructions
// plus hand sequences for stall counting, flush during BUS and reset mid-BUS.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, flush, mem_ack;
  logic [31:0] ex_alu_result, ex_store_data, mem_rdata;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_ready, stall, mem_req, mem_we, wb_valid, wb_reg_write, fault;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rd;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .flush(flush),
    .ex_ready(ex_ready), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] alu, sdata, rdata;
    logic [4:0]  rd;
    logic        rd_en, wr_en, rw;
    logic [2:0]  f3;
    int          k;
    logic        bus;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [31:0] wbd;
    logic        wbrw, flt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rde, input logic wre, input logic rw, input logic [2:0] f3);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_mem_read = rde; ex_mem_write = wre; ex_reg_write = rw; ex_funct3 = f3;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive(v.alu, v.sdata, v.rd, v.rd_en, v.wr_en, v.rw, v.f3);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (v.bus) begin
      chk($sformatf("v%0d req", i), {31'h0, mem_req}, 32'h1);
      chk($sformatf("v%0d we", i), {31'h0, mem_we}, {31'h0, v.wr_en});
      chk($sformatf("v%0d addr", i), mem_addr, v.addr);
      chk($sformatf("v%0d wdata", i), mem_wdata, v.wdata);
      chk($sformatf("v%0d wstrb", i), {28'h0, mem_wstrb}, {28'h0, v.strb});
      chk($sformatf("v%0d ready_bus", i), {31'h0, ex_ready}, 32'h0);
      for (int c = 1; c < v.k; c++) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d req_hold", i), {31'h0, mem_req}, 32'h1);
        chk($sformatf("v%0d addr_hold", i), mem_addr, v.addr);
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    end
    chk($sformatf("v%0d wb_valid", i), {31'h0, wb_valid}, 32'h1);
    chk($sformatf("v%0d wb_data", i), wb_data, v.wbd);
    chk($sformatf("v%0d wb_rw", i), {31'h0, wb_reg_write}, {31'h0, v.wbrw});
    chk($sformatf("v%0d wb_rd", i), {27'h0, wb_rd}, {27'h0, v.rd});
    chk($sformatf("v%0d fault", i), {31'h0, fault}, {31'h0, v.flt});
    chk($sformatf("v%0d req_beat", i), {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    chk($sformatf("v%0d wb_valid_low", i), {31'h0, wb_valid}, 32'h0);
    chk($sformatf("v%0d fault_low", i), {31'h0, fault}, 32'h0);
    chk($sformatf("v%0d ready_back", i), {31'h0, ex_ready}, 32'h1);
    chk($sformatf("v%0d wb_data_held", i), wb_data, v.wbd);
  endtask

  // Flush asserted in the second BUS cycle; the bus access must still finish.
  task automatic flush_seq(input logic is_store);
    if (is_store) drive(32'h700, 32'h0BAD_F00D, 5'd23, 1'b0, 1'b1, 1'b0, 3'b010);
    else          drive(32'h710, 32'h0, 5'd24, 1'b1, 1'b0, 1'b1, 3'b010);
    @(posedge clk); #1;
    chk("fl req1", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    flush = 1'b1;
    chk("fl req2", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl req3", {31'h0, mem_req}, 32'h1);
    chk("fl strb", {28'h0, mem_wstrb}, is_store ? 32'hF : 32'h0);
    chk("fl wdata", mem_wdata, is_store ? 32'h0BAD_F00D : 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_ack = 1'b0; ex_valid = 1'b0;
    chk("fl wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("fl wb_rw", {31'h0, wb_reg_write}, 32'h0);
    if (!is_store) chk("fl wb_data", wb_data, 32'h1357_9BDF);
    @(posedge clk); #1;
    chk("fl ready", {31'h0, ex_ready}, 32'h1);
  endtask

  initial begin
    int cnt;
    //            alu            sdata          rdata          rd  rd wr rw f3      k  bus addr     wdata          strb     wbd            wbrw flt
    vecs[0]  = '{32'h0000_00A5, 32'h0,         32'h0,         5'd5,  0, 0, 1, 3'b000, 1, 0, 32'h0,   32'h0,         4'h0,    32'h0000_00A5, 1, 0};
    vecs[1]  = '{32'h103,       32'h0,         32'h8012_3456, 5'd7,  1, 0, 1, 3'b000, 3, 1, 32'h100, 32'h0,         4'h0,    32'hFFFF_FF80, 1, 0};
    vecs[2]  = '{32'h103,       32'h0,         32'h8012_3456, 5'd8,  1, 0, 1, 3'b100, 3, 1, 32'h100, 32'h0,         4'h0,    32'h0000_0080, 1, 0};
    vecs[3]  = '{32'h202,       32'h1234_BEEF, 32'h0,         5'd9,  0, 1, 1, 3'b001, 1, 1, 32'h200, 32'hBEEF_BEEF, 4'b1100, 32'h202,       0, 0};
    vecs[4]  = '{32'h301,       32'h0,         32'h0,         5'd10, 1, 0, 1, 3'b010, 1, 0, 32'h0,   32'h0,         4'h0,    32'h301,       0, 1};
    vecs[5]  = '{32'h300,       32'h0,         32'h0,         5'd11, 1, 0, 1, 3'b011, 1, 0, 32'h0,   32'h0,         4'h0,    32'h300,       0, 1};
    vecs[6]  = '{32'h106,       32'h0,         32'h8001_7FFF, 5'd12, 1, 0, 1, 3'b001, 2, 1, 32'h104, 32'h0,         4'h0,    32'hFFFF_8001, 1, 0};
    vecs[7]  = '{32'h104,       32'h0,         32'h1234_F00D, 5'd13, 1, 0, 1, 3'b101, 1, 1, 32'h104, 32'h0,         4'h0,    32'h0000_F00D, 1, 0};
    vecs[8]  = '{32'h108,       32'h0,         32'hDEAD_BEEF, 5'd14, 1, 0, 1, 3'b010, 2, 1, 32'h108, 32'h0,         4'h0,    32'hDEAD_BEEF, 1, 0};
    vecs[9]  = '{32'h401,       32'h0000_00AB, 32'h0,         5'd15, 0, 1, 0, 3'b000, 2, 1, 32'h400, 32'hABAB_ABAB, 4'b0010, 32'h401,       0, 0};
    vecs[10] = '{32'h500,       32'hCAFE_F00D, 32'h0,         5'd16, 0, 1, 0, 3'b010, 1, 1, 32'h500, 32'hCAFE_F00D, 4'hF,    32'h500,       0, 0};
    vecs[11] = '{32'h203,       32'h1111_2222, 32'h0,         5'd17, 0, 1, 0, 3'b001, 1, 0, 32'h0,   32'h0,         4'h0,    32'h203,       0, 1};
    vecs[12] = '{32'h100,       32'h0,         32'h0,         5'd18, 1, 1, 1, 3'b010, 1, 0, 32'h0,   32'h0,         4'h0,    32'h100,       0, 1};
    vecs[13] = '{32'h102,       32'h0,         32'h0012_3456, 5'd19, 1, 0, 1, 3'b000, 1, 1, 32'h100, 32'h0,         4'h0,    32'h0000_0012, 1, 0};
    vecs[14] = '{32'hDEAD_0001, 32'h0,         32'h0,         5'd20, 0, 0, 0, 3'b000, 1, 0, 32'h0,   32'h0,         4'h0,    32'hDEAD_0001, 0, 0};
    vecs[15] = '{32'h600,       32'h1,         32'h0,         5'd21, 0, 1, 0, 3'b100, 1, 0, 32'h0,   32'h0,         4'h0,    32'h600,       0, 1};
    vecs[16] = '{32'h100,       32'h0,         32'h1234_56F0, 5'd22, 1, 0, 1, 3'b100, 4, 1, 32'h100, 32'h0,         4'h0,    32'h0000_00F0, 1, 0};

    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0; ex_rd = '0;
    ex_reg_write = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    #23;
    chk("rst ready", {31'h0, ex_ready}, 32'h1);
    chk("rst req", {31'h0, mem_req}, 32'h0);
    chk("rst wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst fault", {31'h0, fault}, 32'h0);
    chk("rst wb_data", wb_data, 32'h0);
    chk("rst wstrb", {28'h0, mem_wstrb}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_vec(i);

    // LB with ack in the third BUS cycle, ex_valid held by the hazard unit
    drive(32'h103, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b000);
    mem_rdata = 32'h80AA_BBCC;
    @(posedge clk); #1;
    chk("st addr", mem_addr, 32'h100);
    cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      if (stall) cnt++;
      mem_ack = (c == 3);
      if (c == 4) begin
        chk("st wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("st wb_data", wb_data, 32'hFFFF_FF80);
      end
      if (c == 5) ex_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("st stall_cycles", cnt, 32'd4);
    chk("st no_reaccept", {31'h0, mem_req}, 32'h0);

    flush_seq(1'b1);
    flush_seq(1'b0);

    // flush on the offered instruction in IDLE: nothing accepted
    drive(32'h55, 32'h0, 5'd25, 1'b0, 1'b0, 1'b1, 3'b000);
    flush = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0;
    chk("fi wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("fi ready", {31'h0, ex_ready}, 32'h1);

    // reset mid-BUS, then a stray ack
    drive(32'h720, 32'h0, 5'd26, 1'b1, 1'b0, 1'b1, 3'b010);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rb req", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rb req_drop", {31'h0, mem_req}, 32'h0);
    chk("rb ready", {31'h0, ex_ready}, 32'h1);
    #2;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rb no_wb1", {31'h0, wb_valid}, 32'h0);
    chk("rb req_idle", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    chk("rb no_wb2", {31'h0, wb_valid}, 32'h0);
    chk("rb ready2", {31'h0, ex_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
